lsu_data_port: RTL and testbench

Load/store unit data port for the memory stage of the pipelined RISC-V core. It accepts one load or store per instruction and issues it to data memory over a req/ack handshake. It holds the pipeline with `stall` until memory acknowledges, then returns aligned, sign- or zero-extended load data. That load data feeds the memory-data input of the write-back select path. Misaligned accesses are never issued; they raise a one-cycle `misaligned` flag toward the CSR/trap logic.

---
 rtl/lsu_data_port.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_data_port.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_port.sv
// rtl/lsu_data_port.sv - load/store unit data port: req/ack memory issue, stall, load alignment
module lsu_data_port #(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  input  logic          i_req_we,
  input  logic [1:0]    i_req_size,
  input  logic          i_req_unsigned,
  input  logic [AW-1:0] i_req_addr,
  input  logic [31:0]   i_req_wdata,
  output logic          o_stall,
  output logic          o_rsp_valid,
  output logic [31:0]   o_rsp_rdata,
  output logic          o_misaligned,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_wstrb,
  input  logic          i_mem_ack,
  input  logic [31:0]   i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Registered memory-side request
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wstrb;

  // Request attributes needed to shape the load response
  logic          r_is_load;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [1:0]    r_lane;
  logic [31:0]   r_rsp_rdata;

  logic          w_size_byte;
  logic          w_size_half;
  logic          w_size_word;
  logic          w_addr_misaligned;
  logic          w_accept;
  logic          w_ack_busy;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata;
  logic [7:0]    w_load_byte;
  logic [15:0]   w_load_half;
  logic [31:0]   w_load_data;

  // Size 2'b11 behaves as a word access
  assign w_size_byte = (i_req_size == 2'b00);
  assign w_size_half = (i_req_size == 2'b01);
  assign w_size_word = i_req_size[1];

  assign w_addr_misaligned = (w_size_half & i_req_addr[0]) |
                             (w_size_word & (|i_req_addr[1:0]));

  // A request is only taken from IDLE; DONE keeps the still-held request from being reissued
  assign w_accept   = (r_state == S_IDLE) & i_req_valid & ~w_addr_misaligned;
  assign w_ack_busy = (r_state == S_BUSY) & i_mem_ack;

  // Store lane strobes and lane-replicated store data
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (i_req_we) begin
      if (w_size_byte) begin
        w_wstrb = 4'b0001 << i_req_addr[1:0];
        w_wdata = {4{i_req_wdata[7:0]}};
      end else if (w_size_half) begin
        w_wstrb = i_req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_req_wdata[15:0]}};
      end else begin
        w_wstrb = 4'b1111;
        w_wdata = i_req_wdata;
      end
    end
  end

  // Select the addressed lane of the returned word and extend it
  always_comb begin
    w_load_byte = 8'h0;
    w_load_half = 16'h0;
    w_load_data = i_mem_rdata;
    case (r_lane)
      2'd0:    w_load_byte = i_mem_rdata[7:0];
      2'd1:    w_load_byte = i_mem_rdata[15:8];
      2'd2:    w_load_byte = i_mem_rdata[23:16];
      default: w_load_byte = i_mem_rdata[31:24];
    endcase
    w_load_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load_data = {{24{~r_unsigned & w_load_byte[7]}}, w_load_byte};
      2'b01:   w_load_data = {{16{~r_unsigned & w_load_half[15]}}, w_load_half};
      default: w_load_data = i_mem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY:  if (i_mem_ack) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; reset forces stall and the misaligned flag low even while a request is presented
  always_comb begin
    o_stall      = 1'b0;
    o_misaligned = 1'b0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall      = i_rst_n & w_accept;
        o_misaligned = i_rst_n & i_req_valid & w_addr_misaligned;
      end
      S_BUSY:  o_stall = 1'b1;
      S_DONE:  o_rsp_valid = r_is_load;
      default: o_stall = 1'b0;
    endcase
  end

  // Memory request registers: loaded on accept, cleared on the acknowledging edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
      r_mem_wstrb <= 4'b0000;
    end else if (w_accept) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= i_req_we;
      r_mem_addr  <= {i_req_addr[AW-1:2], 2'b00};
      r_mem_wdata <= w_wdata;
      r_mem_wstrb <= w_wstrb;
    end else if (w_ack_busy) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
      r_mem_wstrb <= 4'b0000;
    end
  end

  // Capture the attributes the response path needs when the request is taken
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_load  <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
    end else if (w_accept) begin
      r_is_load  <= ~i_req_we;
      r_size     <= i_req_size;
      r_unsigned <= i_req_unsigned;
      r_lane     <= i_req_addr[1:0];
    end
  end

  // Load data register: updated only on a load acknowledge, otherwise holds
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_rdata <= 32'h0;
    end else if (w_ack_busy && r_is_load) begin
      r_rsp_rdata <= w_load_data;
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_lsu_data_port.sv
// tb/tb_lsu_data_port.sv - scoreboard bench for lsu_data_port with random loads/stores
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall, rsp_valid, misaligned, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  lsu_data_port #(.AW(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_stall(stall), .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata), .o_misaligned(misaligned), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wstrb(mem_wstrb), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } mem_t;

  int          checks = 0;
  int          failures = 0;
  mem_t        exp_mem[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] exp_mis[$];
  int          exp_stall[$];
  int          plan_delay[$];
  logic [31:0] plan_rdata[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference load result: shift the addressed lane down, mask, then extend by arithmetic
  function automatic logic [31:0] model_load(logic [31:0] w, bit [1:0] size, bit uns,
                                             logic [1:0] off);
    int unsigned v;
    if (size == 2'd0) begin
      v = (w >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = (w >> (8 * off)) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_strb(bit [1:0] size, logic [1:0] off);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(bit [1:0] size, logic [31:0] d);
    if (size == 2'd0) return (d % 256) * 32'h0101_0101;
    if (size == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // Present one request, record what the DUT must do, and hold it until stall is low
  task automatic issue(input bit we, input bit [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int delay);
    bit   mis;
    mem_t e;
    int   n;
    mis = (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'd0);
    if (mis) begin
      exp_mis.push_back(addr);
    end else begin
      e.we    = we;
      e.addr  = addr - (addr % 4);
      e.wdata = model_wdata(size, wdata);
      e.strb  = we ? model_strb(size, addr[1:0]) : 4'h0;
      exp_mem.push_back(e);
      plan_delay.push_back(delay);
      plan_rdata.push_back(rdata);
      exp_stall.push_back(delay + 2);
      if (!we) exp_rsp.push_back(model_load(rdata, size, uns, addr[1:0]));
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 200) begin
        check("stall_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Memory model: acknowledges each new request after its planned delay, plus stray acks when idle
  initial begin
    bit          in_prog;
    int          cnt, dly;
    logic [31:0] rd;
    in_prog = 0; cnt = 0; dly = 0; rd = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!rst_n) begin
        in_prog = 0;
        continue;
      end
      if (mem_req) begin
        if (!in_prog) begin
          if (plan_delay.size() == 0) begin
            dly = 0; rd = 32'h0;
          end else begin
            dly = plan_delay.pop_front(); rd = plan_rdata.pop_front();
          end
          in_prog = 1; cnt = 0;
        end
        if (cnt == dly) begin
          mem_ack = 1'b1; mem_rdata = rd; in_prog = 0;
        end else begin
          cnt++; mem_rdata = $urandom;
        end
      end else begin
        mem_ack   = ($urandom_range(3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a request, response, flag or stall run
  initial begin
    bit   prev_req;
    int   run;
    mem_t e, cur;
    prev_req = 0; run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 0; run = 0;
        continue;
      end
      if (mem_req && !prev_req) begin
        if (exp_mem.size() == 0) begin
          check("unexpected_mem_req", 32'(mem_req), 32'd0);
        end else begin
          e = exp_mem.pop_front();
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", mem_addr, e.addr);
          check("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        end
        cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata; cur.strb = mem_wstrb;
      end else if (mem_req) begin
        check("hold_we", 32'(mem_we), 32'(cur.we));
        check("hold_addr", mem_addr, cur.addr);
        check("hold_wdata", mem_wdata, cur.wdata);
        check("hold_wstrb", 32'(mem_wstrb), 32'(cur.strb));
      end else begin
        check("idle_we", 32'(mem_we), 32'd0);
        check("idle_addr", mem_addr, 32'd0);
        check("idle_wdata", mem_wdata, 32'd0);
        check("idle_wstrb", 32'(mem_wstrb), 32'd0);
      end
      if (stall) begin
        run++;
      end else if (run > 0) begin
        if (exp_stall.size() == 0) check("unexpected_stall", 32'(run), 32'd0);
        else check("stall_cycles", 32'(run), 32'(exp_stall.pop_front()));
        run = 0;
      end
      if (misaligned) begin
        if (exp_mis.size() == 0) begin
          check("unexpected_misaligned", 32'(misaligned), 32'd0);
        end else begin
          check("misaligned_addr", req_addr, exp_mis.pop_front());
          check("misaligned_stall", 32'(stall), 32'd0);
        end
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        else check("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
      end
      prev_req = mem_req;
    end
  end

  initial begin
    bit [1:0]    sz;
    logic [31:0] a;
    int          n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 2'd2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    issue(0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF_1234, 1);
    issue(0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF_1234, 0);
    issue(0, 2'd1, 0, 32'h102, 32'h0, 32'h80FF_1234, 2);
    issue(1, 2'd0, 0, 32'h201, 32'h1234_565A, 32'h0, 0);
    issue(1, 2'd1, 0, 32'h202, 32'h7777_BEEF, 32'h0, 1);
    issue(0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 0);
    issue(1, 2'd1, 0, 32'h301, 32'hBEEF, 32'h0, 0);
    issue(0, 2'd3, 1, 32'h40C, 32'h0, 32'h8123_4567, 5);
    issue(1, 2'd2, 0, 32'h410, 32'hCAFE_F00D, 32'h0, 0);

    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom_range(3));
      a  = $urandom;
      if ($urandom_range(3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz >= 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(1)), sz, 1'($urandom_range(1)), a, $urandom, $urandom,
            $urandom_range(6));
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end

    // Abandon an access mid-flight with reset
    plan_delay.push_back(40);
    plan_rdata.push_back(32'h1111_2222);
    exp_mem.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0, strb: 4'h0});
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h500;
    n = 0;
    while (!mem_req && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_test_mem_req_seen", 32'(mem_req), 32'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    req_valid = 1'b0;
    exp_mem.delete(); exp_rsp.delete(); exp_stall.delete(); exp_mis.delete();
    plan_delay.delete(); plan_rdata.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_mem_req", 32'(mem_req), 32'd0);
      check("post_rst_stall", 32'(stall), 32'd0);
    end

    check("left_exp_mem", 32'(exp_mem.size()), 32'd0);
    check("left_exp_rsp", 32'(exp_rsp.size()), 32'd0);
    check("left_exp_stall", 32'(exp_stall.size()), 32'd0);
    check("left_exp_mis", 32'(exp_mis.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
